reg_file_mp: RTL and testbench

Parametrised multi-port register file with registered read ports, write-to-read bypass, an optional hardwired zero register and a per-register busy scoreboard. It is the decode/writeback storage of the core pipeline. Decode issues reads and locks destination registers. Writeback writes results and releases the locks. Depth, data width and read-port count are generics, so one block serves integer and auxiliary register banks.

---
 rtl/reg_file_mp.sv | 128 ++++++++++++
 tb/tb_reg_file_mp.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port register file with registered reads, optional write-to-read bypass,
// optional hardwired zero register and a per-register busy scoreboard.
module reg_file_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [XLEN-1:0]     wdata,
  input  logic [NRD-1:0]      re,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                lock_en,
  input  logic [AW-1:0]       lock_addr,
  output logic [DEPTH-1:0]    busy
);

  // An address names real, writable storage: in range and not the hardwired zero.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic in_range;
    logic is_zero;
    in_range = (32'(a) < DEPTH);
    is_zero  = (ZERO_REG != 0) && (a == '0);
    return in_range && !is_zero;
  endfunction

  logic [XLEN-1:0]     mem_q [DEPTH];
  logic [XLEN-1:0]     mem_d [DEPTH];
  logic [DEPTH-1:0]    busy_q;
  logic [DEPTH-1:0]    busy_d;
  logic [NRD*XLEN-1:0] rdata_q;
  logic [NRD*XLEN-1:0] rdata_d;
  logic [NRD-1:0]      rbusy_q;
  logic [NRD-1:0]      rbusy_d;
  logic                wr_ok;
  logic                lk_ok;

  assign wr_ok = we && addr_ok(waddr);
  assign lk_ok = lock_en && addr_ok(lock_addr);

  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      mem_d[r] = mem_q[r];
      if (wr_ok && (waddr == AW'(r))) begin
        mem_d[r] = wdata;
      end
    end
  end

  // Lock is applied after the write clear so a re-issued producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    for (int r = 0; r < DEPTH; r++) begin
      if (wr_ok && (waddr == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
      if (lk_ok && (lock_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  always_comb begin
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;
    rdata_d = rdata_q;
    rbusy_d = rbusy_q;
    ra      = '0;
    rd      = '0;
    rb      = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      ra = raddr[p*AW +: AW];
      rd = '0;
      rb = 1'b0;
      for (int r = 0; r < DEPTH; r++) begin
        if (ra == AW'(r)) begin
          rd = mem_q[r];
          rb = busy_q[r];
        end
      end
      // Forwarded data also carries the releasing write's busy clear.
      if ((BYPASS != 0) && wr_ok && (waddr == ra)) begin
        rd = wdata;
        rb = 1'b0;
      end
      if (!addr_ok(ra)) begin
        rd = '0;
        rb = 1'b0;
      end
      if (re[p]) begin
        rdata_d[p*XLEN +: XLEN] = rd;
        rbusy_d[p]              = rb;
      end
    end
  end

  // Register stage: storage, scoreboard and read-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= '0;
      end
      busy_q  <= '0;
      rdata_q <= '0;
      rbusy_q <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        mem_q[r] <= mem_d[r];
      end
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign rdata = rdata_q;
  assign rbusy = rbusy_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench: a default instance (32 regs, zero reg, bypass) and a variant
// (24 regs, no zero reg, no bypass) share one stimulus stream.
module tb_reg_file_mp;

  localparam int XLEN = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk;
  logic                reset;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   raddr;
  logic                lock_en;
  logic [AW-1:0]       lock_addr;

  logic [NRD*XLEN-1:0] rdata_a;
  logic [NRD-1:0]      rbusy_a;
  logic [31:0]         busy_a;
  logic [NRD*XLEN-1:0] rdata_b;
  logic [NRD-1:0]      rbusy_b;
  logic [23:0]         busy_b;

  int n_assert;
  int n_fail;

  reg_file_mp #(.XLEN(32), .DEPTH(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_a), .rbusy(rbusy_a),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy(busy_a)
  );

  reg_file_mp #(.XLEN(32), .DEPTH(24), .NRD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .re(re), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .lock_en(lock_en), .lock_addr(lock_addr), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    we        = 1'b0;
    waddr     = '0;
    wdata     = '0;
    re        = '0;
    raddr     = '0;
    lock_en   = 1'b0;
    lock_addr = '0;
    step();
    reset = 1'b0;
    chk("rst_busy_a", 64'(busy_a), 64'd0);
    chk("rst_rdata_a", rdata_a, 64'd0);

    // r5 written with bypass read, r6 locked
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    lock_en = 1'b1; lock_addr = 5'd6;
    re = 2'b11; raddr = {5'd5, 5'd5};
    step();
    chk("pre_rst_rdata_a", rdata_a, {32'hDEADBEEF, 32'hDEADBEEF});
    chk("pre_rst_rdata_b", rdata_b, 64'd0);
    chk("pre_rst_busy_a", 64'(busy_a), 64'h40);
    chk("pre_rst_busy_b", 64'(busy_b), 64'h40);

    // Reset beats the same-cycle read
    we = 1'b0; lock_en = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_rdata_a2", rdata_a, 64'd0);
    chk("rst_rdata_b2", rdata_b, 64'd0);
    chk("rst_rbusy_a2", 64'(rbusy_a), 64'd0);
    chk("rst_busy_a2", 64'(busy_a), 64'd0);
    chk("rst_busy_b2", 64'(busy_b), 64'd0);
    step();
    chk("rst_r5_a", rdata_a, 64'd0);
    chk("rst_r5_b", rdata_b, 64'd0);

    // Basic writes and two-port read
    re = 2'b00;
    we = 1'b1; waddr = 5'd3; wdata = 32'h11;
    step();
    waddr = 5'd7; wdata = 32'h22;
    step();
    we = 1'b0;
    re = 2'b11; raddr = {5'd7, 5'd3};
    step();
    chk("basic_a", rdata_a, {32'h22, 32'h11});
    chk("basic_b", rdata_b, {32'h22, 32'h11});
    re = 2'b01; raddr = {5'd3, 5'd3};
    step();
    chk("hold_p1_a", rdata_a, {32'h22, 32'h11});
    chk("hold_p1_b", rdata_b, {32'h22, 32'h11});

    // Bypass
    we = 1'b1; waddr = 5'd9; wdata = 32'hA5A5A5A5;
    re = 2'b01; raddr = {5'd3, 5'd9};
    step();
    we = 1'b0;
    chk("bypass_a", rdata_a, {32'h22, 32'hA5A5A5A5});
    chk("nobypass_b", rdata_b, {32'h22, 32'h0});
    step();
    chk("late_read_b", rdata_b, {32'h22, 32'hA5A5A5A5});

    // Zero register
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
    lock_en = 1'b1; lock_addr = 5'd0;
    re = 2'b01; raddr = {5'd3, 5'd0};
    step();
    we = 1'b0; lock_en = 1'b0;
    chk("zero_rd_a", rdata_a, {32'h22, 32'h0});
    chk("zero_busy_a", 64'(busy_a[0]), 64'd0);
    chk("r0_lock_b", 64'(busy_b[0]), 64'd1);
    step();
    chk("zero_rd2_a", rdata_a, {32'h22, 32'h0});
    chk("zero_rbusy_a", 64'(rbusy_a), 64'd0);
    chk("r0_rd_b", rdata_b, {32'h22, 32'hFFFFFFFF});
    chk("r0_rbusy_b", 64'(rbusy_b), 64'd1);

    // Scoreboard on r4
    re = 2'b00;
    lock_en = 1'b1; lock_addr = 5'd4;
    step();
    lock_en = 1'b0;
    chk("lock4_a", 64'(busy_a[4]), 64'd1);
    chk("lock4_b", 64'(busy_b[4]), 64'd1);
    re = 2'b01; raddr = {5'd3, 5'd4};
    step();
    chk("rbusy4_a", 64'(rbusy_a[0]), 64'd1);
    chk("rbusy4_b", 64'(rbusy_b[0]), 64'd1);
    we = 1'b1; waddr = 5'd4; wdata = 32'h7;
    step();
    chk("rel4_rd_a", rdata_a, {32'h22, 32'h7});
    chk("rel4_rbusy_a", 64'(rbusy_a[0]), 64'd0);
    chk("rel4_busy_a", 64'(busy_a[4]), 64'd0);
    chk("rel4_rd_b", rdata_b, {32'h22, 32'h0});
    chk("rel4_rbusy_b", 64'(rbusy_b[0]), 64'd1);
    chk("rel4_busy_b", 64'(busy_b[4]), 64'd0);
    re = 2'b00; wdata = 32'h8;
    lock_en = 1'b1; lock_addr = 5'd4;
    step();
    we = 1'b0; lock_en = 1'b0;
    chk("lockwin_a", 64'(busy_a[4]), 64'd1);
    chk("lockwin_b", 64'(busy_b[4]), 64'd1);

    // Out of range for the 24-deep instance
    we = 1'b1; waddr = 5'd30; wdata = 32'h55;
    lock_en = 1'b1; lock_addr = 5'd25;
    re = 2'b01; raddr = {5'd3, 5'd30};
    step();
    we = 1'b0; lock_en = 1'b0;
    chk("oor_rd_b", rdata_b, {32'h22, 32'h0});
    chk("oor_rbusy_b", 64'(rbusy_b[0]), 64'd0);
    chk("oor_busy_b", 64'(busy_b), 64'h11);
    chk("inr_rd_a", rdata_a, {32'h22, 32'h55});
    chk("inr_busy_a", 64'(busy_a), 64'h0200_0010);
    re = 2'b11; raddr = {5'd9, 5'd30};
    step();
    chk("oor_rd2_b", rdata_b, {32'hA5A5A5A5, 32'h0});
    chk("inr_rd2_a", rdata_a, {32'hA5A5A5A5, 32'h55});
    chk("oor_rbusy2_b", 64'(rbusy_b), 64'd0);
    raddr = {5'd3, 5'd6};
    step();
    chk("oor_alias_b", rdata_b, {32'h11, 32'h0});
    chk("r6_a", rdata_a, {32'h11, 32'h0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
